// File: rtl/xo_format_encoder.sv
// ============================================================================
// xo_format_encoder
// ----------------------------------------------------------------------------
// Builds POWER ISA 3.0B XO-format (primary opcode 31) instruction words from
// operand fields. The bit placement matches the XO decode stage. Encoded words
// are queued in a small FIFO and presented one per cycle to the decode-side
// consumer. Unsupported extended opcodes are consumed, dropped and counted.
//
// Ports (vectors are big-endian, bit 0 = MSB):
//   clock_i        in   rising-edge clock
//   reset_i        in   synchronous active-high reset
//   enable_i       in   request valid; consumed when enable_i && ready_o
//   xOpCode_i      in   extended opcode (XO)
//   reg1_i         in   RT
//   reg2_i         in   RA
//   reg3_i         in   RB
//   bit1_i         in   OE
//   bit2_i         in   Rc
//   ready_o        out  FIFO not full (state-derived only)
//   instruction_o  out  FIFO head word, zero while the FIFO is empty
//   enable_o       out  FIFO non-empty; instruction_o valid
//   stall_i        in   consumer stall; head popped on enable_o && !stall_i
//   error_o        out  one-cycle pulse after an unsupported XO is consumed
//   errorCount_o   out  saturating count of rejected requests
//   occupancy_o    out  FIFO entry count, 0..fifoDepth
// ============================================================================
module xo_format_encoder #(
    parameter int unsigned opcodeWidth      = 6,
    parameter int unsigned xOpCodeWidth     = 9,
    parameter int unsigned regWidth         = 5,
    parameter int unsigned instructionWidth = 32,
    parameter int unsigned fifoDepth        = 4,
    parameter int unsigned countWidth       = 8
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [0:xOpCodeWidth-1]       xOpCode_i,
    input  logic [0:regWidth-1]           reg1_i,
    input  logic [0:regWidth-1]           reg2_i,
    input  logic [0:regWidth-1]           reg3_i,
    input  logic                          bit1_i,
    input  logic                          bit2_i,
    output logic                          ready_o,
    output logic [0:instructionWidth-1]   instruction_o,
    output logic                          enable_o,
    input  logic                          stall_i,
    output logic                          error_o,
    output logic [0:countWidth-1]         errorCount_o,
    output logic [0:$clog2(fifoDepth)]    occupancy_o
);

    localparam int unsigned ptrWidth = $clog2(fifoDepth);
    localparam int unsigned occWidth = ptrWidth + 1;

    localparam logic [opcodeWidth-1:0] primaryOpcode = opcodeWidth'(31);
    localparam logic [occWidth-1:0]    fullCount     = occWidth'(fifoDepth);

    // ------------------------------------------------------------------------
    // Request decode and field sanitising
    // ------------------------------------------------------------------------
    logic [xOpCodeWidth-1:0]     xo;
    logic [regWidth-1:0]         rt;
    logic [regWidth-1:0]         ra;
    logic [regWidth-1:0]         rb;
    logic                        oe;
    logic                        rc;
    logic                        supported;
    logic [instructionWidth-1:0] word;

    // Internal copies use descending ranges; assignment keeps the MSB aligned.
    assign xo = xOpCode_i;

    always_comb begin
        case (int'(xo))
            8, 9, 10, 11, 40, 73, 74, 104, 136, 138, 200, 202, 232, 233,
            234, 235, 266, 393, 395, 425, 427, 457, 459, 489, 491:
                supported = 1'b1;
            default:
                supported = 1'b0;
        endcase
    end

    // Reserved fields are forced to zero so the decode stage never sees
    // stray operand bits for forms that do not use them.
    always_comb begin
        rt = reg1_i;
        ra = reg2_i;
        rb = reg3_i;
        oe = bit1_i;
        rc = bit2_i;
        case (int'(xo))
            104, 200, 202, 232, 234: rb = '0;
            9, 11, 73:               oe = 1'b0;
            74: begin
                oe = 1'b0;
                rc = 1'b0;
            end
            default: ;
        endcase
        // [0:5]=31 [6:10]=RT [11:15]=RA [16:20]=RB [21]=OE [22:30]=XO [31]=Rc
        word = {primaryOpcode, rt, ra, rb, oe, xo, rc};
    end

    // ------------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------------
    logic [instructionWidth-1:0] mem [fifoDepth];
    logic [ptrWidth-1:0]         rd_ptr;
    logic [ptrWidth-1:0]         wr_ptr;
    logic [occWidth-1:0]         count;
    logic                        not_empty;
    logic                        accept;
    logic                        push;
    logic                        pop;
    logic                        reject;

    // ready depends only on the registered count, so a pop while full cannot
    // open a push slot in the same cycle and stall_i never reaches ready_o.
    assign ready_o   = (count != fullCount);
    assign not_empty = (count != '0);
    assign accept    = enable_i && ready_o;
    assign push      = accept && supported;
    assign reject    = accept && !supported;
    assign pop       = not_empty && !stall_i;

    always_ff @(posedge clock_i) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because fifoDepth is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + ptrWidth'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + ptrWidth'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + occWidth'(1);
                2'b01:   count <= count - occWidth'(1);
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Reject reporting
    // ------------------------------------------------------------------------
    logic                  err_pulse;
    logic [countWidth-1:0] err_count;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            err_pulse <= 1'b0;
            err_count <= '0;
        end else begin
            err_pulse <= reject;
            if (reject && (err_count != '1)) begin
                err_count <= err_count + countWidth'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign enable_o      = not_empty;
    assign instruction_o = not_empty ? mem[rd_ptr] : '0;
    assign error_o       = err_pulse;
    assign errorCount_o  = err_count;
    assign occupancy_o   = count;

endmodule

// File: tb/tb_xo_format_encoder.sv
module tb_xo_format_encoder;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic        enable_i;
    logic [0:8]  xOpCode_i;
    logic [0:4]  reg1_i;
    logic [0:4]  reg2_i;
    logic [0:4]  reg3_i;
    logic        bit1_i;
    logic        bit2_i;
    logic        ready_o;
    logic [0:31] instruction_o;
    logic        enable_o;
    logic        stall_i;
    logic        error_o;
    logic [0:7]  errorCount_o;
    logic [0:2]  occupancy_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model state
    bit [31:0]   mq[$];
    int unsigned m_cnt = 0;
    bit          m_err = 1'b0;
    bit          last_accept = 1'b0;

    int supported_list[25] = '{8, 9, 10, 11, 40, 73, 74, 104, 136, 138, 200,
                               202, 232, 233, 234, 235, 266, 393, 395, 425,
                               427, 457, 459, 489, 491};

    xo_format_encoder #(
        .opcodeWidth(6),
        .xOpCodeWidth(9),
        .regWidth(5),
        .instructionWidth(32),
        .fifoDepth(4),
        .countWidth(8)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .enable_i(enable_i),
        .xOpCode_i(xOpCode_i),
        .reg1_i(reg1_i),
        .reg2_i(reg2_i),
        .reg3_i(reg3_i),
        .bit1_i(bit1_i),
        .bit2_i(bit2_i),
        .ready_o(ready_o),
        .instruction_o(instruction_o),
        .enable_o(enable_o),
        .stall_i(stall_i),
        .error_o(error_o),
        .errorCount_o(errorCount_o),
        .occupancy_o(occupancy_o)
    );

    always #5 clock_i = ~clock_i;

    function automatic bit is_sup(int x);
        foreach (supported_list[i]) begin
            if (supported_list[i] == x) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit [31:0] ref_word(int xo, int rt, int ra, int rb, int oe, int rc);
        longint v;
        if (xo inside {104, 200, 202, 232, 234}) rb = 0;
        if (xo inside {9, 11, 73, 74}) oe = 0;
        if (xo == 74) rc = 0;
        v = 31 * (longint'(1) << 26) + rt * (1 << 21) + ra * (1 << 16)
          + rb * (1 << 11) + oe * (1 << 10) + xo * 2 + rc;
        return v[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int xo, input int rt, input int ra, input int rb,
                           input int oe, input int rc);
        xOpCode_i = 9'(xo);
        reg1_i    = 5'(rt);
        reg2_i    = 5'(ra);
        reg3_i    = 5'(rb);
        bit1_i    = oe[0];
        bit2_i    = rc[0];
    endtask

    task automatic set_random_req();
        int xo;
        if ($urandom_range(0, 9) < 7) xo = supported_list[$urandom_range(0, 24)];
        else xo = $urandom_range(0, 511);
        set_req(xo, $urandom_range(0, 31), $urandom_range(0, 31),
                $urandom_range(0, 31), $urandom_range(0, 1), $urandom_range(0, 1));
    endtask

    // One clock: predict from the inputs seen at the edge, then compare all
    // observable outputs shortly after the edge.
    task automatic step(input string tag);
        bit        ready;
        bit        accept;
        bit        pop;
        bit        sup;
        bit [31:0] w;
        ready  = (mq.size() != 4);
        accept = enable_i && ready;
        sup    = is_sup(int'(xOpCode_i));
        w      = ref_word(int'(xOpCode_i), int'(reg1_i), int'(reg2_i),
                          int'(reg3_i), int'(bit1_i), int'(bit2_i));
        pop    = (mq.size() != 0) && !stall_i;
        @(posedge clock_i);
        #1;
        if (reset_i) begin
            mq.delete();
            m_cnt       = 0;
            m_err       = 1'b0;
            last_accept = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (accept && sup) mq.push_back(w);
            m_err = accept && !sup;
            if (m_err && m_cnt < 255) m_cnt++;
            last_accept = accept;
        end
        chk($sformatf("%s/enable", tag), 32'(enable_o), 32'(mq.size() != 0));
        chk($sformatf("%s/word", tag), instruction_o, (mq.size() != 0) ? mq[0] : 32'h0);
        chk($sformatf("%s/occ", tag), 32'(occupancy_o), mq.size());
        chk($sformatf("%s/ready", tag), 32'(ready_o), 32'(mq.size() != 4));
        chk($sformatf("%s/err", tag), 32'(error_o), 32'(m_err));
        chk($sformatf("%s/errcnt", tag), 32'(errorCount_o), m_cnt);
    endtask

    initial begin
        bit got5;
        reset_i  = 1'b1;
        enable_i = 1'b0;
        stall_i  = 1'b0;
        set_req(0, 0, 0, 0, 0, 0);
        step("reset0");
        step("reset1");
        reset_i = 1'b0;
        step("idle");
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_word", instruction_o, 32'h0);

        // Basic encoding
        set_req(266, 3, 4, 5, 0, 1);
        enable_i = 1'b1;
        step("t1");
        enable_i = 1'b0;
        chk("t1_word_const", instruction_o, 32'h7C642A15);
        step("t1_drain");
        chk("t1_empty", 32'(enable_o), 32'd0);

        // RB forced to zero
        set_req(104, 1, 2, 7, 1, 0);
        enable_i = 1'b1;
        step("t2");
        enable_i = 1'b0;
        chk("t2_word_const", instruction_o, 32'h7C2204D0);
        step("t2_drain");

        // Unsupported XO
        set_req(5, 1, 1, 1, 1, 1);
        enable_i = 1'b1;
        step("t3");
        enable_i = 1'b0;
        chk("t3_err_const", 32'(error_o), 32'd1);
        chk("t3_cnt_const", 32'(errorCount_o), 32'd1);
        step("t3_after");
        chk("t3_pulse_end", 32'(error_o), 32'd0);

        // Fill under stall, hold the fifth request, then drain
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_req(supported_list[(i * 7) % 25], i + 1, i + 2, i + 3, 1, 1);
            enable_i = 1'b1;
            step($sformatf("t4_fill%0d", i));
        end
        chk("t4_full_ready", 32'(ready_o), 32'd0);
        chk("t4_full_occ", 32'(occupancy_o), 32'd4);
        set_req(491, 9, 10, 11, 1, 0);
        step("t4_hold0");
        step("t4_hold1");
        chk("t4_hold_occ", 32'(occupancy_o), 32'd4);
        stall_i = 1'b0;
        got5 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step($sformatf("t4_drain%0d", i));
            if (last_accept && enable_i) begin
                got5     = 1'b1;
                enable_i = 1'b0;
            end
        end
        chk("t4_fifth_accepted", 32'(got5), 32'd1);

        // Saturating reject counter
        set_req(0, 0, 0, 0, 0, 0);
        enable_i = 1'b1;
        for (int i = 0; i < 300; i++) step("t5");
        enable_i = 1'b0;
        chk("t5_sat_const", 32'(errorCount_o), 32'd255);
        step("t5_idle");

        // Reset with words queued and a push pending
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_req(266, i, i, i, 0, 1);
            enable_i = 1'b1;
            step("t6_fill");
        end
        chk("t6_occ3", 32'(occupancy_o), 32'd3);
        set_req(8, 1, 2, 3, 1, 1);
        reset_i = 1'b1;
        step("t6_reset");
        reset_i  = 1'b0;
        enable_i = 1'b0;
        stall_i  = 1'b0;
        chk("t6_enable_const", 32'(enable_o), 32'd0);
        chk("t6_occ_const", 32'(occupancy_o), 32'd0);
        chk("t6_cnt_const", 32'(errorCount_o), 32'd0);
        chk("t6_ready_const", 32'(ready_o), 32'd1);
        step("t6_idle");

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            enable_i = ($urandom_range(0, 3) != 0);
            stall_i  = ($urandom_range(0, 2) == 0);
            set_random_req();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
